// File: rtl/qar_gpio_ctrl.sv
// qar_gpio_ctrl: memory-mapped GPIO with synchronised inputs, atomic set/clear/toggle
// writes on OUT, and per-pin edge-detect interrupts with sticky write-one-to-clear status.
module qar_gpio_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic [WIDTH-1:0]      gpio_in,
  output logic [WIDTH-1:0]      gpio_out,
  output logic [WIDTH-1:0]      gpio_dir,
  output logic                  irq
);

  localparam int OW = ADDR_WIDTH - 2;

  localparam logic [OW-1:0] OFF_DIR  = OW'(4'h0);
  localparam logic [OW-1:0] OFF_OUT  = OW'(4'h1);
  localparam logic [OW-1:0] OFF_IN   = OW'(4'h2);
  localparam logic [OW-1:0] OFF_SET  = OW'(4'h3);
  localparam logic [OW-1:0] OFF_CLR  = OW'(4'h4);
  localparam logic [OW-1:0] OFF_TGL  = OW'(4'h5);
  localparam logic [OW-1:0] OFF_EN   = OW'(4'h6);
  localparam logic [OW-1:0] OFF_RISE = OW'(4'h7);
  localparam logic [OW-1:0] OFF_BOTH = OW'(4'h8);
  localparam logic [OW-1:0] OFF_STAT = OW'(4'h9);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RESP = 1'b1;

  logic             state_r;
  logic [31:0]      rdata_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] en_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] both_r;
  logic [WIDTH-1:0] status_r;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;

  logic [OW-1:0]    off_s;
  logic             acc_s;
  logic             wr_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] sync_in_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] evt_s;
  logic [WIDTH-1:0] w1c_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign off_s     = mem_addr[ADDR_WIDTH-1:2];
  assign acc_s     = (state_r == ST_IDLE) && mem_valid;
  assign wr_s      = acc_s && mem_we;
  assign wdata_s   = mem_wdata[WIDTH-1:0];
  assign unused_s  = ^{mem_addr[1:0], mem_wdata};

  assign sync_in_s = sync_r[SYNC_STAGES-1];
  assign rise_s    = sync_in_s & ~prev_r;
  assign fall_s    = ~sync_in_s & prev_r;
  // BOTH takes precedence over RISE for each pin.
  assign evt_s     = en_r & ((both_r & (rise_s | fall_s)) |
                             (~both_r & rise_r & rise_s) |
                             (~both_r & ~rise_r & fall_s));
  assign w1c_s     = (wr_s && (off_s == OFF_STAT)) ? wdata_s : {WIDTH{1'b0}};

  assign mem_ready = (state_r == ST_RESP);
  assign mem_rdata = rdata_r;
  assign gpio_out  = out_r;
  assign gpio_dir  = dir_r;
  assign irq       = |(status_r & en_r);

  // Read-data mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      OFF_DIR:  rdata_s = 32'(dir_r);
      OFF_OUT:  rdata_s = 32'(out_r);
      OFF_IN:   rdata_s = 32'(sync_in_s);
      OFF_EN:   rdata_s = 32'(en_r);
      OFF_RISE: rdata_s = 32'(rise_r);
      OFF_BOTH: rdata_s = 32'(both_r);
      OFF_STAT: rdata_s = 32'(status_r);
      default:  rdata_s = 32'd0;
    endcase
  end

  // Handshake FSM: accept in IDLE, present ready/rdata for one cycle in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rdata_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_valid) begin
            state_r <= ST_RESP;
            rdata_r <= mem_we ? 32'd0 : rdata_s;
          end else begin
            state_r <= ST_IDLE;
            rdata_r <= 32'd0;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          rdata_r <= 32'd0;
        end
        default: begin
          state_r <= ST_IDLE;
          rdata_r <= 32'd0;
        end
      endcase
    end
  end

  // Bus-writable configuration and output registers, OUT with atomic set/clear/toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_r  <= {WIDTH{1'b0}};
      out_r  <= {WIDTH{1'b0}};
      en_r   <= {WIDTH{1'b0}};
      rise_r <= {WIDTH{1'b0}};
      both_r <= {WIDTH{1'b0}};
    end else if (wr_s) begin
      case (off_s)
        OFF_DIR:  dir_r  <= wdata_s;
        OFF_OUT:  out_r  <= wdata_s;
        OFF_SET:  out_r  <= out_r | wdata_s;
        OFF_CLR:  out_r  <= out_r & ~wdata_s;
        OFF_TGL:  out_r  <= out_r ^ wdata_s;
        OFF_EN:   en_r   <= wdata_s;
        OFF_RISE: rise_r <= wdata_s;
        OFF_BOTH: both_r <= wdata_s;
        default:  dir_r  <= dir_r;
      endcase
    end else begin
      dir_r <= dir_r;
    end
  end

  // Sticky status: a new event in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_r <= {WIDTH{1'b0}};
    end else begin
      status_r <= (status_r & ~w1c_s) | evt_s;
    end
  end

  // Input synchroniser chain plus one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
      prev_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_in_s;
    end
  end

endmodule

// File: tb/tb_qar_gpio_ctrl.sv
// Scoreboard bench for qar_gpio_ctrl: a 32-pin and an 8-pin instance share one bus and
// pin set; a behavioural model predicts register contents, read data and interrupts.
module tb_qar_gpio_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [5:0]  mem_addr = 6'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] gpio_in = 32'd0;

  logic        mem_ready, irq;
  logic [31:0] mem_rdata, gpio_out, gpio_dir;
  logic        mem_ready8, irq8;
  logic [31:0] mem_rdata8;
  logic [7:0]  gpio_out8, gpio_dir8;

  qar_gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(S), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_dir(gpio_dir), .irq(irq));

  qar_gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(S), .ADDR_WIDTH(6)) dut8 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready8), .mem_rdata(mem_rdata8),
    .gpio_in(gpio_in[7:0]), .gpio_out(gpio_out8), .gpio_dir(gpio_dir8), .irq(irq8));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (32-bit view; the 8-pin instance is its low byte).
  logic [31:0] m_dir = 32'd0, m_out = 32'd0, m_en = 32'd0;
  logic [31:0] m_rise = 32'd0, m_both = 32'd0, m_status = 32'd0;
  logic [31:0] samp [0:S];
  logic        busy = 1'b0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pins are seen by the controller S clocks after sampling; an edge between the
  // two most recent synchronised values raises status on the following clock.
  initial begin : model
    logic [31:0] s_now, p_now, rise, fall, evt, w1c, rd;
    logic [5:0]  off;
    for (int i = 0; i <= S; i++) samp[i] = 32'd0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_dir = 32'd0; m_out = 32'd0; m_en = 32'd0;
        m_rise = 32'd0; m_both = 32'd0; m_status = 32'd0;
        busy = 1'b0;
        exp_q.delete();
        for (int i = 0; i <= S; i++) samp[i] = 32'd0;
      end else begin
        s_now = samp[S-1];
        p_now = samp[S];
        rise  = s_now & ~p_now;
        fall  = ~s_now & p_now;
        evt   = 32'd0;
        for (int i = 0; i < 32; i++) begin
          if (m_en[i]) evt[i] = m_both[i] ? (rise[i] | fall[i]) : (m_rise[i] ? rise[i] : fall[i]);
        end
        w1c = 32'd0;
        if (busy) begin
          busy = 1'b0;
        end else if (mem_valid) begin
          busy = 1'b1;
          off  = {mem_addr[5:2], 2'b00};
          if (!mem_we) begin
            case (off)
              6'h00:   rd = m_dir;
              6'h04:   rd = m_out;
              6'h08:   rd = s_now;
              6'h18:   rd = m_en;
              6'h1C:   rd = m_rise;
              6'h20:   rd = m_both;
              6'h24:   rd = m_status;
              default: rd = 32'd0;
            endcase
            exp_q.push_back(rd);
          end else begin
            exp_q.push_back(32'd0);
            case (off)
              6'h00:   m_dir  = mem_wdata;
              6'h04:   m_out  = mem_wdata;
              6'h0C:   m_out  = m_out | mem_wdata;
              6'h10:   m_out  = m_out & ~mem_wdata;
              6'h14:   m_out  = m_out ^ mem_wdata;
              6'h18:   m_en   = mem_wdata;
              6'h1C:   m_rise = mem_wdata;
              6'h20:   m_both = mem_wdata;
              6'h24:   w1c    = mem_wdata;
              default: w1c    = 32'd0;
            endcase
          end
        end
        m_status = (m_status & ~w1c) | evt;
        for (int i = S; i > 0; i--) samp[i] = samp[i-1];
        samp[0] = gpio_in;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT responds; checks pins and irq each cycle.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_ready", {31'd0, mem_ready}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", mem_rdata, e);
            chk("rdata8", mem_rdata8, e & 32'h0000_00FF);
            chk("ready8", {31'd0, mem_ready8}, 32'd1);
          end
        end else begin
          chk("rdata_idle", mem_rdata, 32'd0);
        end
        chk("gpio_out", gpio_out, m_out);
        chk("gpio_dir", gpio_dir, m_dir);
        chk("irq", {31'd0, irq}, {31'd0, |(m_status & m_en)});
        chk("gpio_out8", {24'd0, gpio_out8}, {24'd0, m_out[7:0]});
        chk("gpio_dir8", {24'd0, gpio_dir8}, {24'd0, m_dir[7:0]});
        chk("irq8", {31'd0, irq8}, {31'd0, |(m_status[7:0] & m_en[7:0])});
      end
    end
  end

  // Called at a negedge; returns at a negedge one cycle after the ready pulse.
  task automatic xfer(input logic we, input logic [5:0] addr, input logic [31:0] wd);
    int cyc;
    mem_valid = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    cyc = 0;
    @(negedge clk);
    while (!mem_ready && cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_seen", {31'd0, mem_ready}, 32'd1);
    chk("latency", 32'(cyc), 32'd0);
    mem_valid = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk("ready_pulse", {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", gpio_out, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_out", gpio_out, 32'd0);
    chk("idle_dir", gpio_dir, 32'd0);
    chk("idle_irq", {31'd0, irq}, 32'd0);
    chk("idle_ready", {31'd0, mem_ready}, 32'd0);
    xfer(1'b0, 6'h00, 32'd0);

    // Atomic OUT operations
    xfer(1'b1, 6'h00, 32'h0000_00FF); chk("dir_ff", gpio_dir, 32'h0000_00FF);
    xfer(1'b1, 6'h04, 32'h0000_000F);
    xfer(1'b1, 6'h0C, 32'h0000_00F0); chk("set", gpio_out, 32'h0000_00FF);
    xfer(1'b1, 6'h10, 32'h0000_0003); chk("clr", gpio_out, 32'h0000_00FC);
    xfer(1'b1, 6'h14, 32'h0000_0081); chk("tgl", gpio_out, 32'h0000_007D);
    xfer(1'b0, 6'h04, 32'd0);
    xfer(1'b0, 6'h0C, 32'd0);

    // Synchroniser latency: reads sampled at 1..4 edges after the pin change
    gpio_in[3] = 1'b1;
    xfer(1'b0, 6'h08, 32'd0);
    xfer(1'b0, 6'h08, 32'd0);
    gpio_in[4] = 1'b1;
    idle(1);
    xfer(1'b0, 6'h08, 32'd0);
    xfer(1'b0, 6'h08, 32'd0);

    // Edge interrupts
    xfer(1'b1, 6'h18, 32'h3);
    xfer(1'b1, 6'h1C, 32'h1);
    xfer(1'b1, 6'h20, 32'h2);
    gpio_in[0] = 1'b1; idle(2); gpio_in[0] = 1'b0; idle(6);
    xfer(1'b0, 6'h24, 32'd0);
    gpio_in[1] = 1'b1; idle(4); gpio_in[1] = 1'b0; idle(6);
    xfer(1'b0, 6'h24, 32'd0);
    chk("irq_both", {31'd0, irq}, 32'd1);
    xfer(1'b1, 6'h24, 32'h1);
    xfer(1'b0, 6'h24, 32'd0);
    chk("irq_after_w1c0", {31'd0, irq}, 32'd1);
    xfer(1'b1, 6'h24, 32'h2);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Set wins: W1C accepted on the same edge the rising event lands
    gpio_in[0] = 1'b1; idle(2);
    xfer(1'b1, 6'h24, 32'h1);
    chk("set_wins_irq", {31'd0, irq}, 32'd1);
    xfer(1'b0, 6'h24, 32'd0);
    xfer(1'b1, 6'h24, 32'h1);
    xfer(1'b0, 6'h24, 32'd0);

    // Randomised traffic and pin activity
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0) gpio_in = $urandom;
      else gpio_in[$urandom_range(0, 31)] = ~gpio_in[$urandom_range(0, 31)];
      idle($urandom_range(0, 2));
      xfer(1'($urandom), 6'($urandom), $urandom);
    end

    // Width truncation and unmapped offset
    xfer(1'b1, 6'h04, 32'hFFFF_FFFF);
    chk("out8_full", {24'd0, gpio_out8}, 32'h0000_00FF);
    xfer(1'b0, 6'h04, 32'd0);
    xfer(1'b0, 6'h3C, 32'd0);

    // Reset during RESP aborts the response immediately
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 6'h04;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, mem_ready}, 32'd0);
    chk("abort_ready8", {31'd0, mem_ready8}, 32'd0);
    chk("abort_rdata", mem_rdata, 32'd0);
    chk("abort_out", gpio_out, 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(1'b0, 6'h04, 32'd0);
    xfer(1'b0, 6'h00, 32'd0);
    xfer(1'b0, 6'h18, 32'd0);

    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
